// File: rtl/hashtable_lookup_arb_pkg.sv
// Shared definitions for the hashtable lookup arbiter: default hashtable
// latency and the tag that travels alongside each lookup while the
// hashtable is busy answering it.
package pigasus_ht_pkg;

    localparam int HT_LAT       = 3;
    localparam int HT_MAX_IDW   = 3;
    localparam int HT_MAX_NBITS = 32;

    // Tag fields are sized for the largest supported configuration; a
    // smaller instance simply leaves the upper bits at zero.
    typedef struct packed {
        logic                    valid;
        logic [HT_MAX_IDW-1:0]   id;
        logic [HT_MAX_NBITS-1:0] addr;
    } lookup_tag_t;

    // Build a tag, clearing every field when the slot is empty so that
    // downstream result fields read as zero without extra gating.
    function automatic lookup_tag_t makeTag(
        input logic                    valid,
        input logic [HT_MAX_IDW-1:0]   id,
        input logic [HT_MAX_NBITS-1:0] addr
    );
        lookup_tag_t t;
        t = '0;
        if (valid) begin
            t.valid = 1'b1;
            t.id    = id;
            t.addr  = addr;
        end
        return t;
    endfunction

endpackage

// File: rtl/hashtable_lookup_arb_rr_pick.sv
// Cyclic first-set picker: starting at ptr_i and wrapping around, return
// the first requester that is valid and not excluded. N must be a power
// of two so the pointer arithmetic wraps naturally.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  exclude_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    logic [N-1:0]  cand;
    logic [PW-1:0] probe;
    logic          foundC;
    logic [PW-1:0] idxC;

    assign cand = valid_i & ~exclude_i;

    // Walk the requesters in cyclic order from the pointer and latch onto
    // the first candidate seen.
    always_comb begin
        foundC = 1'b0;
        idxC   = '0;
        probe  = '0;
        for (int k = 0; k < N; k++) begin
            probe = ptr_i + PW'(k);
            if (!foundC && cand[probe]) begin
                foundC = 1'b1;
                idxC   = probe;
            end
        end
    end

    assign found_o  = foundC;
    assign idx_o    = idxC;
    assign onehot_o = foundC ? (N'(1) << idxC) : '0;

endmodule

// File: rtl/hashtable_lookup_arb.sv
// Two-port hashtable lookup arbiter. Up to two requesters are granted per
// cycle in round-robin order, their addresses are registered onto the two
// hashtable ports, and a fixed-latency tag pipeline re-associates each
// returned hit flag with the requester and address that produced it.
module hashtable_lookup_arb
    import pigasus_ht_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 15,
    parameter int LAT   = HT_LAT,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*NBITS-1:0] req_addr,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output logic [NBITS-1:0]      ht_addr0,
    output logic [NBITS-1:0]      ht_addr1,
    output logic                  ht_addr0_valid,
    output logic                  ht_addr1_valid,
    input  logic                  ht_dout0_valid,
    input  logic                  ht_dout1_valid,
    output logic                  res0_valid,
    output logic                  res1_valid,
    output logic [IDW-1:0]        res0_id,
    output logic [IDW-1:0]        res1_id,
    output logic [NBITS-1:0]      res0_addr,
    output logic [NBITS-1:0]      res1_addr,
    output logic                  res0_hit,
    output logic                  res1_hit,
    output logic                  busy,
    output logic [31:0]           lookup_cnt,
    output logic [31:0]           hit_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rrPtrQ;
    logic [PW-1:0]   rrPtrD;
    logic            found0;
    logic            found1;
    logic [PW-1:0]   idx0;
    logic [PW-1:0]   idx1;
    logic [NREQ-1:0] onehot0;
    logic [NREQ-1:0] onehot1;
    logic [NREQ-1:0] noExclude;
    logic [NREQ-1:0] grant;

    lookup_tag_t portTagD [2];
    lookup_tag_t portTagQ [2];
    lookup_tag_t pipeQ    [2][LAT];
    lookup_tag_t tail     [2];

    logic [31:0] lookupCntQ;
    logic [31:0] hitCntQ;
    logic        unusedTagBits;

    assign noExclude = '0;

    // Port 0 takes the first valid requester at or after the pointer.
    rr_pick #(.N(NREQ), .PW(PW)) pick0 (
        .valid_i   (req_valid),
        .ptr_i     (rrPtrQ),
        .exclude_i (noExclude),
        .found_o   (found0),
        .idx_o     (idx0),
        .onehot_o  (onehot0)
    );

    // Port 1 repeats the search with port 0's winner masked out, which
    // yields the next valid requester after it in cyclic order.
    rr_pick #(.N(NREQ), .PW(PW)) pick1 (
        .valid_i   (req_valid),
        .ptr_i     (rrPtrQ),
        .exclude_i (onehot0),
        .found_o   (found1),
        .idx_o     (idx1),
        .onehot_o  (onehot1)
    );

    assign grant     = onehot0 | onehot1;
    assign req_ready = rst ? '0 : grant;

    // Advance the pointer just past the last requester served this cycle;
    // port 1 is always later in the cyclic order than port 0.
    always_comb begin
        rrPtrD = rrPtrQ;
        if (found1) begin
            rrPtrD = idx1 + PW'(1);
        end else if (found0) begin
            rrPtrD = idx0 + PW'(1);
        end
    end

    // Capture the granted requester id and address for each port.
    always_comb begin
        portTagD[0] = makeTag(found0, HT_MAX_IDW'(idx0),
                              HT_MAX_NBITS'(req_addr[idx0*NBITS +: NBITS]));
        portTagD[1] = makeTag(found1, HT_MAX_IDW'(idx1),
                              HT_MAX_NBITS'(req_addr[idx1*NBITS +: NBITS]));
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtrQ <= '0;
        end else begin
            rrPtrQ <= rrPtrD;
        end
    end

    // Port registers feed the hashtable; the tag pipeline shadows the
    // hashtable latency one stage per cycle and never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                portTagQ[p] <= '0;
                for (int k = 0; k < LAT; k++) begin
                    pipeQ[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                portTagQ[p] <= portTagD[p];
                pipeQ[p][0] <= portTagQ[p];
                for (int k = 1; k < LAT; k++) begin
                    pipeQ[p][k] <= pipeQ[p][k-1];
                end
            end
        end
    end

    assign ht_addr0       = portTagQ[0].addr[NBITS-1:0];
    assign ht_addr1       = portTagQ[1].addr[NBITS-1:0];
    assign ht_addr0_valid = portTagQ[0].valid;
    assign ht_addr1_valid = portTagQ[1].valid;

    assign tail[0] = pipeQ[0][LAT-1];
    assign tail[1] = pipeQ[1][LAT-1];

    // Tag bits beyond the configured id/address widths carry nothing.
    assign unusedTagBits = ^{tail[0], tail[1]};

    // Results pair the pipeline tail with the hit flag arriving this cycle.
    always_comb begin
        res0_valid = tail[0].valid;
        res1_valid = tail[1].valid;
        res0_hit   = tail[0].valid & ht_dout0_valid;
        res1_hit   = tail[1].valid & ht_dout1_valid;
        res0_id    = tail[0].valid ? tail[0].id[IDW-1:0]     : '0;
        res1_id    = tail[1].valid ? tail[1].id[IDW-1:0]     : '0;
        res0_addr  = tail[0].valid ? tail[0].addr[NBITS-1:0] : '0;
        res1_addr  = tail[1].valid ? tail[1].addr[NBITS-1:0] : '0;
    end

    // Anything sitting in a port register or tag stage means work in flight.
    always_comb begin
        busy = portTagQ[0].valid | portTagQ[1].valid;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | pipeQ[0][k].valid | pipeQ[1][k].valid;
        end
    end

    // Running totals of completed lookups and hits; both ports may
    // complete together so each counter can step by two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookupCntQ <= '0;
            hitCntQ    <= '0;
        end else begin
            lookupCntQ <= lookupCntQ + 32'(res0_valid) + 32'(res1_valid);
            hitCntQ    <= hitCntQ + 32'(res0_hit) + 32'(res1_hit);
        end
    end

    assign lookup_cnt = lookupCntQ;
    assign hit_cnt    = hitCntQ;

endmodule

// File: tb/tb_hashtable_lookup_arb.sv
// Testbench for hashtable_lookup_arb: a hand-derived grant table, directed
// corner sequences and randomized traffic, all checked every cycle against
// a cycle-indexed reference model of grants, results and counters.
module tb_hashtable_lookup_arb;

    localparam int NREQ  = 4;
    localparam int NBITS = 15;
    localparam int LAT   = 3;
    localparam int IDW   = 2;
    localparam int RING  = 64;

    logic                  clk;
    logic                  rst;
    logic [NREQ*NBITS-1:0] req_addr;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NBITS-1:0]      ht_addr0, ht_addr1;
    logic                  ht_addr0_valid, ht_addr1_valid;
    logic                  ht_dout0_valid, ht_dout1_valid;
    logic                  res0_valid, res1_valid;
    logic [IDW-1:0]        res0_id, res1_id;
    logic [NBITS-1:0]      res0_addr, res1_addr;
    logic                  res0_hit, res1_hit;
    logic                  busy;
    logic [31:0]           lookup_cnt, hit_cnt;

    hashtable_lookup_arb #(
        .NREQ(NREQ), .NBITS(NBITS), .LAT(LAT), .IDW(IDW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_addr       (req_addr),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .ht_addr0       (ht_addr0),
        .ht_addr1       (ht_addr1),
        .ht_addr0_valid (ht_addr0_valid),
        .ht_addr1_valid (ht_addr1_valid),
        .ht_dout0_valid (ht_dout0_valid),
        .ht_dout1_valid (ht_dout1_valid),
        .res0_valid     (res0_valid),
        .res1_valid     (res1_valid),
        .res0_id        (res0_id),
        .res1_id        (res1_id),
        .res0_addr      (res0_addr),
        .res1_addr      (res1_addr),
        .res0_hit       (res0_hit),
        .res1_hit       (res1_hit),
        .busy           (busy),
        .lookup_cnt     (lookup_cnt),
        .hit_cnt        (hit_cnt)
    );

    // Free-running clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever loses its way.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic             v;
        logic [IDW-1:0]   id;
        logic [NBITS-1:0] addr;
    } ent_t;

    typedef struct {
        logic [NREQ-1:0] v;
        logic            d0;
        logic            d1;
        logic [NREQ-1:0] expReady;
    } vec_t;

    ent_t        ring [RING][2];
    int          cyc;
    int          rrM;
    logic [31:0] cntL;
    logic [31:0] cntH;
    int          checks;
    int          errors;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int slotAt(input int c);
        return ((c % RING) + RING) % RING;
    endfunction

    // List valid requesters in cyclic order from the pointer; the first two
    // on that list are the port 0 and port 1 winners (-1 when absent).
    task automatic computeGrants(input logic [NREQ-1:0] v, input int ptr, output int g0, output int g1);
        int j;
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (v[j]) begin
                if (g0 < 0) g0 = j;
                else if (g1 < 0) g1 = j;
            end
        end
    endtask

    task automatic clearModel();
        for (int s = 0; s < RING; s++) begin
            for (int p = 0; p < 2; p++) begin
                ring[s][p].v    = 1'b0;
                ring[s][p].id   = '0;
                ring[s][p].addr = '0;
            end
        end
        rrM  = 0;
        cntL = '0;
        cntH = '0;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*NBITS-1:0] a,
                                 input logic d0, input logic d1);
        req_valid      = v;
        req_addr       = a;
        ht_dout0_valid = d0;
        ht_dout1_valid = d1;
    endtask

    // Compare every output against what the model predicts for this cycle.
    task automatic checkOutput(input logic [NREQ-1:0] v, input logic d0, input logic d1,
                               input logic [NREQ-1:0] tblReady, input bit useTbl);
        int              g0, g1;
        logic [NREQ-1:0] expReady;
        ent_t            pe, re;
        logic            expBusy, dN;
        logic            aV, rV, rH;
        logic [NBITS-1:0] aA, rA;
        logic [IDW-1:0]  rI;
        computeGrants(v, rrM, g0, g1);
        expReady = '0;
        if (g0 >= 0) expReady[g0] = 1'b1;
        if (g1 >= 0) expReady[g1] = 1'b1;
        checkEq("req_ready", 32'(req_ready), 32'(expReady));
        if (useTbl) checkEq("tbl_req_ready", 32'(req_ready), 32'(tblReady));
        for (int p = 0; p < 2; p++) begin
            pe = ring[slotAt(cyc - 1)][p];
            re = ring[slotAt(cyc - 1 - LAT)][p];
            dN = (p == 0) ? d0 : d1;
            aV = (p == 0) ? ht_addr0_valid : ht_addr1_valid;
            aA = (p == 0) ? ht_addr0 : ht_addr1;
            rV = (p == 0) ? res0_valid : res1_valid;
            rH = (p == 0) ? res0_hit : res1_hit;
            rI = (p == 0) ? res0_id : res1_id;
            rA = (p == 0) ? res0_addr : res1_addr;
            checkEq($sformatf("ht_addr%0d_valid", p), 32'(aV), 32'(pe.v));
            if (pe.v) checkEq($sformatf("ht_addr%0d", p), 32'(aA), 32'(pe.addr));
            checkEq($sformatf("res%0d_valid", p), 32'(rV), 32'(re.v));
            checkEq($sformatf("res%0d_hit", p), 32'(rH), 32'(re.v & dN));
            checkEq($sformatf("res%0d_id", p), 32'(rI), re.v ? 32'(re.id) : 32'h0);
            checkEq($sformatf("res%0d_addr", p), 32'(rA), re.v ? 32'(re.addr) : 32'h0);
        end
        expBusy = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            expBusy = expBusy | ring[slotAt(cyc - k)][0].v | ring[slotAt(cyc - k)][1].v;
        end
        checkEq("busy", 32'(busy), 32'(expBusy));
        checkEq("lookup_cnt", lookup_cnt, cntL);
        checkEq("hit_cnt", hit_cnt, cntH);
    endtask

    // Record this cycle's grants and fold completed lookups into the totals.
    task automatic modelAdvance(input logic [NREQ-1:0] v, input logic [NREQ*NBITS-1:0] a,
                                input logic d0, input logic d1);
        int   g0, g1;
        int   gs [2];
        ent_t re;
        logic dN;
        computeGrants(v, rrM, g0, g1);
        gs[0] = g0;
        gs[1] = g1;
        for (int p = 0; p < 2; p++) begin
            re = ring[slotAt(cyc - 1 - LAT)][p];
            dN = (p == 0) ? d0 : d1;
            cntL = cntL + 32'(re.v);
            cntH = cntH + 32'(re.v & dN);
        end
        for (int p = 0; p < 2; p++) begin
            if (gs[p] >= 0) begin
                ring[slotAt(cyc)][p].v    = 1'b1;
                ring[slotAt(cyc)][p].id   = IDW'(gs[p]);
                ring[slotAt(cyc)][p].addr = a[gs[p]*NBITS +: NBITS];
            end else begin
                ring[slotAt(cyc)][p].v    = 1'b0;
                ring[slotAt(cyc)][p].id   = '0;
                ring[slotAt(cyc)][p].addr = '0;
            end
        end
        if (g1 >= 0) rrM = (g1 + 1) % NREQ;
        else if (g0 >= 0) rrM = (g0 + 1) % NREQ;
        cyc++;
    endtask

    // One clock cycle: entered at a falling edge, leaves at the next one.
    task automatic stepCycle(input logic [NREQ-1:0] v, input logic [NREQ*NBITS-1:0] a,
                             input logic d0, input logic d1,
                             input logic [NREQ-1:0] tblReady, input bit useTbl);
        applyStimulus(v, a, d0, d1);
        #1;
        checkOutput(v, d0, d1, tblReady, useTbl);
        modelAdvance(v, a, d0, d1);
        @(negedge clk);
    endtask

    task automatic checkResetZeros(input string tag);
        checkEq({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkEq({tag, "_ht_addr0_valid"}, 32'(ht_addr0_valid), 32'h0);
        checkEq({tag, "_ht_addr1_valid"}, 32'(ht_addr1_valid), 32'h0);
        checkEq({tag, "_res0_valid"}, 32'(res0_valid), 32'h0);
        checkEq({tag, "_res1_valid"}, 32'(res1_valid), 32'h0);
        checkEq({tag, "_res0_hit"}, 32'(res0_hit), 32'h0);
        checkEq({tag, "_res1_hit"}, 32'(res1_hit), 32'h0);
        checkEq({tag, "_res0_id"}, 32'(res0_id), 32'h0);
        checkEq({tag, "_res1_id"}, 32'(res1_id), 32'h0);
        checkEq({tag, "_res0_addr"}, 32'(res0_addr), 32'h0);
        checkEq({tag, "_res1_addr"}, 32'(res1_addr), 32'h0);
        checkEq({tag, "_busy"}, 32'(busy), 32'h0);
        checkEq({tag, "_lookup_cnt"}, lookup_cnt, 32'h0);
        checkEq({tag, "_hit_cnt"}, hit_cnt, 32'h0);
    endtask

    // Hold reset for two cycles with every requester asking, then release
    // on a falling edge so the very next rising edge can grant.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus('1, '1, 1'b1, 1'b1);
        #1;
        checkResetZeros("rst0");
        @(negedge clk);
        #1;
        checkResetZeros("rst1");
        clearModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [NREQ*NBITS-1:0] randAddr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NREQ*NBITS-1:0];
    endfunction

    vec_t                  tbl [10];
    logic [NREQ*NBITS-1:0] a;
    logic [31:0]           hitsBefore;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        clearModel();
        @(negedge clk);
        doReset();

        // Grant sequence worked out by hand from a freshly reset pointer.
        tbl[0] = '{4'b1111, 1'b0, 1'b0, 4'b0011};
        tbl[1] = '{4'b1111, 1'b1, 1'b0, 4'b1100};
        tbl[2] = '{4'b1111, 1'b0, 1'b1, 4'b0011};
        tbl[3] = '{4'b0100, 1'b1, 1'b1, 4'b0100};
        tbl[4] = '{4'b1001, 1'b1, 1'b0, 4'b1001};
        tbl[5] = '{4'b0001, 1'b0, 1'b1, 4'b0001};
        tbl[6] = '{4'b0000, 1'b1, 1'b1, 4'b0000};
        tbl[7] = '{4'b0011, 1'b0, 1'b0, 4'b0011};
        tbl[8] = '{4'b1010, 1'b1, 1'b0, 4'b1010};
        tbl[9] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
        for (int i = 0; i < 10; i++) begin
            a = randAddr();
            if (i == 3) a[2*NBITS +: NBITS] = 15'h1234;
            stepCycle(tbl[i].v, a, tbl[i].d0, tbl[i].d1, tbl[i].expReady, 1'b1);
        end
        for (int i = 0; i < LAT + 2; i++) stepCycle('0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Double completion on top of a saturated lookup counter: the
        // counter must wrap through zero and keep both counts.
        stepCycle(4'b0011, randAddr(), 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < LAT; i++) stepCycle('0, '0, 1'b0, 1'b0, '0, 1'b0);
        force dut.lookupCntQ = 32'hFFFFFFFF;
        #1;
        release dut.lookupCntQ;
        cntL       = 32'hFFFFFFFF;
        hitsBefore = cntH;
        stepCycle('0, '0, 1'b1, 1'b0, '0, 1'b0);
        #1;
        checkEq("lookup_cnt_wrap", lookup_cnt, 32'h1);
        checkEq("hit_cnt_plus1", hit_cnt, hitsBefore + 32'h1);
        for (int i = 0; i < 2; i++) stepCycle('0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Reset while a burst of four lookups is still in flight.
        stepCycle(4'b1111, randAddr(), 1'b0, 1'b0, '0, 1'b0);
        stepCycle(4'b1111, randAddr(), 1'b0, 1'b0, '0, 1'b0);
        stepCycle('0, '0, 1'b1, 1'b1, '0, 1'b0);
        stepCycle('0, '0, 1'b1, 1'b1, '0, 1'b0);
        doReset();
        for (int i = 0; i < LAT + 3; i++) stepCycle('0, '0, 1'b1, 1'b1, '0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) doReset();
            stepCycle(NREQ'($urandom), randAddr(), 1'($urandom), 1'($urandom), '0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hashtable_lookup_arb.md
HASHTABLE_LOOKUP_ARB -- requirements
Module: hashtable_lookup_arb

Interface
REQ-001 Parameter NREQ, default 4; number of lookup requesters, power of two, 2..8.
REQ-002 Parameter NBITS, default 15; hashtable address width.
REQ-003 Parameter LAT, default 3; fixed hashtable latency, address-valid cycle to dout_valid cycle.
REQ-004 Parameter IDW, default $clog2(NREQ); requester-id width.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_addr  in  NREQ*NBITS  lookup address per requester; requester i occupies bits [i*NBITS +: NBITS].
- req_valid  in  NREQ  lookup request per requester.
- req_ready  out  NREQ  grant; a request is consumed when valid and ready are both high.
- ht_addr0, ht_addr1  out  NBITS  hashtable port addresses.
- ht_addr0_valid, ht_addr1_valid  out  1  hashtable port strobes.
- ht_dout0_valid, ht_dout1_valid  in  1  hashtable hit flags; the returned address is not consumed.
- res0_valid, res1_valid  out  1  lookup completed.
- res0_id, res1_id  out  IDW  requester that issued the lookup.
- res0_addr, res1_addr  out  NBITS  address that was looked up.
- res0_hit, res1_hit  out  1  bitmap bit was set.
- busy  out  1  at least one lookup is in flight.
- lookup_cnt, hit_cnt  out  32  completed lookups and hits, both ports summed, wrapping.

Function
REQ-006 Up to two grants per cycle, combinational from req_valid and rr_ptr; req_ready[i] is high only when req_valid[i] is high and requester i is granted.
REQ-007 Port 0 grant goes to the first valid requester at or after rr_ptr, searching cyclically; port 1 grant goes to the next valid requester after that; one requester never receives both ports in the same cycle.
REQ-008 With exactly one valid requester, only port 0 is used; ht_addr1_valid stays 0.
REQ-009 rr_ptr updates to (last granted index + 1) mod NREQ and holds when nothing is granted; the wrap from NREQ-1 to 0 is required.
REQ-010 ht_addrN and ht_addrN_valid are registered; a grant in cycle t drives the port in cycle t+1.
REQ-011 Each port has a tag pipeline of depth LAT carrying {valid, id, addr}; it advances every cycle and has no stall.
REQ-012 resN_valid is asserted in cycle t+1+LAT for a grant in cycle t, with resN_hit = ht_doutN_valid sampled in that cycle; results are not registered a second time.
REQ-013 A tag-pipeline output with valid low forces resN_valid = 0 and resN_hit = 0.
REQ-014 resN_id and resN_addr are 0 whenever resN_valid = 0.
REQ-015 busy = OR of the valid bits in both tag pipelines and both port-output registers.
REQ-016 lookup_cnt adds res0_valid + res1_valid each cycle; hit_cnt adds (res0_valid & res0_hit) + (res1_valid & res1_hit); both wrap modulo 2^32.
REQ-017 When both ports complete in the same cycle, both counters add 2 and do not drop a count.
REQ-018 Back-to-back throughput: two lookups per cycle sustained, with no bubbles inserted by the arbiter.

Reset
REQ-019 While rst is high, the following are 0: rr_ptr, all tag-pipeline valids, ht_addr*_valid, res*_valid, res*_hit, res*_id, res*_addr, req_ready, busy, lookup_cnt, hit_cnt.
REQ-020 Reset mid-operation discards in-flight lookups, and no result for them is emitted after rst deasserts.
REQ-021 The first grant can occur in the first rising edge after rst deasserts.

Structure
REQ-022 A shared package pigasus_ht_pkg holds HT_LAT (= 3) and the lookup-tag struct {valid, id, addr}.
REQ-023 Sub-module rr_pick (cyclic first-set from pointer, with an exclude mask) is instantiated twice: once for port 0, and once for port 1 with port 0's grant excluded.

Verification
REQ-024 All four requesters valid continuously from rr_ptr = 0 -> grant pairs (0,1), (2,3), (0,1), ...; each res appears exactly 4 cycles after its grant.
REQ-025 Only requester 2 valid, addr 0x1234 -> ht_addr0 = 0x1234 in the next cycle, ht_addr1_valid = 0, res0_id = 2 and res0_addr = 0x1234 four cycles after the grant.
REQ-026 Model drives ht_dout0_valid = 1 and ht_dout1_valid = 0 at result time -> res0_hit = 1, res1_hit = 0, lookup_cnt += 2, hit_cnt += 1.
REQ-027 rr_ptr = 3 with requesters 3 and 0 valid -> port 0 grants 3, port 1 grants 0, rr_ptr becomes 1.
REQ-028 rst pulsed two cycles after a burst of 4 grants -> no res*_valid afterwards, busy = 0, counters = 0.
REQ-029 Preload lookup_cnt to 0xFFFFFFFF via a forced double completion -> value wraps to 0x00000001.
